// File: rtl/hue_sequencer.sv
// hue_sequencer
//   Steps through six hue segments and tells three downstream fade engines
//   (R, G, B) what to do in each one. Automatic sequencing is timer driven
//   while RUNNING. Manual single-segment steps are accepted only while PAUSED.
//
//   Ports
//     clk        single clock
//     rst_n      asynchronous active-low reset (release synchronised internally)
//     run        level: 1 = sequence automatically, 0 = pause
//     dir        0 = forward (0->5), 1 = reverse (5->0); honoured only when
//                HUE_SEQ_REVERSE_EN is defined, otherwise ignored
//     step_req   manual advance request (rising edge, PAUSED only)
//     step_ack   one-cycle acknowledge, aligned with the stepped seg_idx
//     seg_idx    current segment 0..5
//     r/g/b_state per-channel fade command: 00 INC, 01 DEC, 10 HIGH, 11 LOW
//     fade_en    registered, 1 while RUNNING
//     seg_start  one-cycle pulse with every new seg_idx
//     wrap       one-cycle pulse when seg_idx wraps (5->0 fwd, 0->5 rev)
//
//   Build option: HUE_SEQ_REVERSE_EN enables reverse sequencing via dir.
module hue_sequencer #(
    parameter int SEGMENT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       dir,
    input  logic       step_req,
    output logic       step_ack,
    output logic [2:0] seg_idx,
    output logic [1:0] r_state,
    output logic [1:0] g_state,
    output logic [1:0] b_state,
    output logic       fade_en,
    output logic       seg_start,
    output logic       wrap
);
    localparam int            CW       = $clog2(SEGMENT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(SEGMENT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUNNING, PAUSED} state_t;
    typedef enum logic [1:0] {INC = 2'b00, DEC = 2'b01, HIGH = 2'b10, LOW = 2'b11} fade_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    seg_nxt;
    logic [1:0]    rst_sync;
    logic          rst_ok;
    logic          step_q;
    logic          adv, step_acc, wrap_nxt, rev;

`ifdef HUE_SEQ_REVERSE_EN
    assign rev = dir;
`else
    // Forward-only build: dir stays on the port but never steers the index.
    assign rev = dir & 1'b0;
`endif

    // Release synchroniser: the FSM may only leave IDLE once both stages
    // have seen rst_n high, so release never races the first state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_ok = rst_sync[1];

    // Next state, advance request and step acceptance.
    always_comb begin
        state_nxt = state;
        adv       = 1'b0;
        step_acc  = 1'b0;
        case (state)
            IDLE:    if (run && rst_ok) state_nxt = RUNNING;
            RUNNING: begin
                // Terminal count advances even if run drops on this cycle.
                adv = (cnt == CNT_LAST);
                if (!run) state_nxt = PAUSED;
            end
            PAUSED:  begin
                step_acc = step_req & ~step_q;
                adv      = step_acc;
                if (run) state_nxt = RUNNING;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Segment counter: counts in RUNNING, freezes in PAUSED, zero in IDLE.
    always_comb begin
        cnt_nxt = cnt;
        case (state)
            RUNNING: cnt_nxt = adv ? '0 : cnt + CW'(1);
            PAUSED:  if (step_acc) cnt_nxt = '0;
            default: cnt_nxt = '0;
        endcase
    end

    // Segment index update; 6/7 are illegal and fall back to 0.
    always_comb begin
        seg_nxt  = seg_idx;
        wrap_nxt = 1'b0;
        if (seg_idx > 3'd5) begin
            seg_nxt = 3'd0;
        end else if (adv) begin
            if (rev) begin
                wrap_nxt = (seg_idx == 3'd0);
                seg_nxt  = wrap_nxt ? 3'd5 : seg_idx - 3'd1;
            end else begin
                wrap_nxt = (seg_idx == 3'd5);
                seg_nxt  = wrap_nxt ? 3'd0 : seg_idx + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            seg_idx   <= 3'd0;
            fade_en   <= 1'b0;
            seg_start <= 1'b0;
            wrap      <= 1'b0;
            step_ack  <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            seg_idx   <= seg_nxt;
            // Registered from the next state so it tracks RUNNING exactly.
            fade_en   <= (state_nxt == RUNNING);
            // Pulses register alongside seg_idx so they line up with it.
            seg_start <= (seg_nxt != seg_idx);
            wrap      <= wrap_nxt;
            step_ack  <= step_acc;
            // Edge detector runs in every state, so a level held across
            // RUNNING->PAUSED is not mistaken for a fresh request.
            step_q    <= step_req;
        end
    end

    // Per-segment channel commands.
    always_comb begin
        case (seg_idx)
            3'd0:    {r_state, g_state, b_state} = {HIGH, INC,  LOW };
            3'd1:    {r_state, g_state, b_state} = {DEC,  HIGH, LOW };
            3'd2:    {r_state, g_state, b_state} = {LOW,  HIGH, INC };
            3'd3:    {r_state, g_state, b_state} = {LOW,  DEC,  HIGH};
            3'd4:    {r_state, g_state, b_state} = {INC,  LOW,  HIGH};
            3'd5:    {r_state, g_state, b_state} = {HIGH, LOW,  DEC };
            default: {r_state, g_state, b_state} = {LOW,  LOW,  LOW };
        endcase
    end
endmodule

// File: tb/tb_hue_sequencer.sv
// tb_hue_sequencer
//   Directed scenarios followed by randomised run/dir/step/reset traffic,
//   every cycle compared against a segment-level reference model.
module tb_hue_sequencer;
    localparam int SC = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;

    logic clk, rst_n, run, dir, step_req;
    logic step_ack, fade_en, seg_start, wrap;
    logic [2:0] seg_idx;
    logic [1:0] r_state, g_state, b_state;

    hue_sequencer #(.SEGMENT_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .dir(dir), .step_req(step_req),
        .step_ack(step_ack), .seg_idx(seg_idx), .r_state(r_state),
        .g_state(g_state), .b_state(b_state), .fade_en(fade_en),
        .seg_start(seg_start), .wrap(wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int m_mode, m_elapsed, m_seg, m_sync;
    bit m_start, m_wrap, m_ack, m_fade, m_prev;
    logic [5:0] dec_tbl [0:5];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        failures++;
        $error("FAIL %s: bound expired", tag);
    endtask

    task automatic m_reset();
        m_mode = M_IDLE; m_elapsed = 0; m_seg = 0; m_sync = 0;
        m_start = 0; m_wrap = 0; m_ack = 0; m_fade = 0; m_prev = 0;
    endtask

    // One clock edge of the behavioural model, using the inputs as sampled.
    task automatic model_edge();
        bit adv, stp, rv;
        if (!rst_n) begin
            m_reset();
            return;
        end
`ifdef HUE_SEQ_REVERSE_EN
        rv = dir;
`else
        rv = 1'b0;
`endif
        adv = 0; stp = 0;
        case (m_mode)
            M_IDLE: begin
                m_elapsed = 0;
                if (run && m_sync >= 2) m_mode = M_RUN;
            end
            M_RUN: begin
                if (m_elapsed == SC - 1) begin adv = 1; m_elapsed = 0; end
                else m_elapsed++;
                if (!run) m_mode = M_PAUSE;
            end
            default: begin
                if (step_req && !m_prev) begin adv = 1; stp = 1; m_elapsed = 0; end
                if (run) m_mode = M_RUN;
            end
        endcase
        m_wrap = adv && (rv ? (m_seg == 0) : (m_seg == 5));
        if (adv) m_seg = rv ? (m_seg + 5) % 6 : (m_seg + 1) % 6;
        m_start = adv;
        m_ack   = stp;
        m_fade  = (m_mode == M_RUN);
        m_prev  = step_req;
        if (m_sync < 2) m_sync++;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".seg"},   32'(seg_idx),   32'(m_seg));
        chk({tag, ".rgb"},   32'({r_state, g_state, b_state}), 32'(dec_tbl[m_seg]));
        chk({tag, ".fade"},  32'(fade_en),   32'(m_fade));
        chk({tag, ".start"}, 32'(seg_start), 32'(m_start));
        chk({tag, ".wrap"},  32'(wrap),      32'(m_wrap));
        chk({tag, ".ack"},   32'(step_ack),  32'(m_ack));
        chk({tag, ".cnt"},   32'(dut.cnt),   32'(m_elapsed));
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk_all(tag);
    endtask

    // Asynchronous assert between edges, checked immediately, held two edges.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        m_reset();
        chk_all(tag);
        repeat (2) cyc({tag, ".hold"});
        rst_n = 1'b1;
    endtask

    initial begin
        bit hit;
        dec_tbl[0] = 6'b10_00_11; dec_tbl[1] = 6'b01_10_11;
        dec_tbl[2] = 6'b11_10_00; dec_tbl[3] = 6'b11_01_10;
        dec_tbl[4] = 6'b00_11_10; dec_tbl[5] = 6'b10_11_01;
        rst_n = 1'b1; run = 0; dir = 0; step_req = 0;
        m_reset();
        @(posedge clk); #1;
        do_reset("por");
        repeat (3) cyc("idle");

        // Free run through a full wrap and beyond.
        run = 1;
        repeat (30) cyc("free");

        // Pause/resume: counter must freeze and fade_en drop.
        run = 0; repeat (10) cyc("pause");
        chk("pause.fade0", 32'(fade_en), 32'd0);
        run = 1; repeat (6) cyc("resume");
        run = 0; repeat (10) cyc("pause2");
        run = 1; repeat (10) cyc("resume2");

        // Manual steps in PAUSED up to segment 3, then pulse + held high.
        run = 0; cyc("to_pause");
        hit = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_mode == M_PAUSE && m_seg == 3 && !step_req) begin hit = 1; break; end
            step_req = ~step_req;
            cyc("walk");
        end
        if (!hit) timeout("step_walk");
        step_req = 1; cyc("step");
        chk("step.seg4", 32'(seg_idx), 32'd4);
        chk("step.ack1", 32'(step_ack), 32'd1);
        chk("step.cnt0", 32'(dut.cnt), 32'd0);
        repeat (5) cyc("held");
        chk("held.seg4", 32'(seg_idx), 32'd4);
        step_req = 0; repeat (2) cyc("rel");

        // Step edges while RUNNING must be ignored.
        run = 1; cyc("run_ign");
        repeat (4) begin step_req = ~step_req; cyc("run_ign"); end
        step_req = 0;

        // run drops on the terminal-count cycle of segment 1.
        hit = 0;
        for (int i = 0; i < 100; i++) begin
            if (m_mode == M_RUN && m_seg == 1 && m_elapsed == SC - 1) begin hit = 1; break; end
            cyc("seek1");
        end
        if (!hit) timeout("seek_tc1");
        run = 0; cyc("tc_fall");
        chk("tc_fall.seg2", 32'(seg_idx), 32'd2);
        chk("tc_fall.fade0", 32'(fade_en), 32'd0);
        cyc("tc_fall2");

`ifdef HUE_SEQ_REVERSE_EN
        // Reverse wrap from segment 0.
        run = 1; dir = 0;
        hit = 0;
        for (int i = 0; i < 100; i++) begin
            if (m_mode == M_RUN && m_seg == 0 && m_elapsed == SC - 1) begin hit = 1; break; end
            cyc("seek0");
        end
        if (!hit) timeout("seek_tc0");
        dir = 1; cyc("rev_wrap");
        chk("rev.seg5", 32'(seg_idx), 32'd5);
        chk("rev.wrap", 32'(wrap), 32'd1);
        chk("rev.rgb", 32'({r_state, g_state, b_state}), 32'(6'b10_11_01));
        repeat (10) cyc("rev_run");
        dir = 0;
`endif

        // Reset at counter 3 of segment 4.
        run = 1;
        hit = 0;
        for (int i = 0; i < 100; i++) begin
            if (m_mode == M_RUN && m_seg == 4 && m_elapsed == 3) begin hit = 1; break; end
            cyc("seek4");
        end
        if (!hit) timeout("seek_seg4");
        do_reset("midrst");
        repeat (8) cyc("after_rst");

        // Randomised traffic.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(7) == 0)  run = ~run;
            if ($urandom_range(15) == 0) dir = ~dir;
            step_req = ($urandom_range(2) == 0);
            if ($urandom_range(99) == 0) do_reset("rnd_rst");
            else cyc("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
